// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack sequencer and the register_stack datapath.
package stack_ctrl_pkg;

    // Stack commands understood by register_stack
    localparam logic [2:0] SOP_NOP      = 3'd0;
    localparam logic [2:0] SOP_PUSH     = 3'd1;
    localparam logic [2:0] SOP_POP      = 3'd2;
    localparam logic [2:0] SOP_POP2PUSH = 3'd3;
    localparam logic [2:0] SOP_CLEAR    = 3'd4;

    // Instruction opcodes
    localparam logic [1:0] OP_PUSHI = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_ALU   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Error codes
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COMMIT = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    // Stack-bound check for an instruction about to be accepted
    function automatic logic [1:0] instr_err_code(
        input logic [1:0] op,
        input logic       full,
        input logic       empty,
        input logic       lt2
    );
        logic [1:0] code;
        code = ERR_NONE;
        case (op)
            OP_PUSHI: if (full)  code = ERR_OVF;
            OP_POP:   if (empty) code = ERR_UNF;
            OP_ALU:   if (lt2)   code = ERR_UNF;
            default:  code = ERR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Stack occupancy counter with full/empty/fewer-than-two status.
module stack_depth_tracker #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc,
    input  logic                         dec,
    input  logic                         clr,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         lt2
);

    localparam int DW = $clog2(DEPTH + 1);

    // Occupancy register; clear wins, callers never raise inc and dec together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= '0;
        end else if (clr) begin
            depth <= '0;
        end else if (inc) begin
            depth <= depth + DW'(1);
        end else if (dec) begin
            depth <= depth - DW'(1);
        end
    end

    // Status decode used by the accept-time bound checks
    always_comb begin
        full  = (depth == DW'(DEPTH));
        empty = (depth == '0);
        lt2   = (depth <= DW'(1));
    end

endmodule

// File: rtl/stack_sequencer.sv
// Instruction-level controller driving registered stack/ALU/mux controls.
module stack_sequencer
    import stack_ctrl_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 1,
    parameter int W       = 16
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [1:0]                   instr_op,
    input  logic [W-1:0]                 instr_imm,
    input  logic [3:0]                   instr_alu,
    input  logic                         Overflow,
    output logic [2:0]                   stackOP,
    output logic [3:0]                   aluOP,
    output logic                         mux_selector,
    output logic [W-1:0]                 immediate,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic                         ovf_flag,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [1:0]         cur_op, cur_op_nx;
    logic [2:0]         stack_op_nx;
    logic [3:0]         alu_op_nx;
    logic               mux_sel_nx;
    logic [W-1:0]       imm_nx;
    logic               done_nx, err_nx, ovf_nx;
    logic [1:0]         err_code_nx, chk_code;
    logic               depth_inc, depth_dec, depth_clr;
    logic               full, empty, lt2;

    stack_depth_tracker #(.DEPTH(DEPTH)) u_depth (
        .clk   (CLK),
        .reset (reset),
        .inc   (depth_inc),
        .dec   (depth_dec),
        .clr   (depth_clr),
        .depth (depth),
        .full  (full),
        .empty (empty),
        .lt2   (lt2)
    );

    assign instr_ready = (state == S_IDLE);
    assign chk_code    = instr_err_code(instr_op, full, empty, lt2);

    // State and registered control outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cur_op       <= OP_PUSHI;
            stackOP      <= SOP_NOP;
            aluOP        <= '0;
            mux_selector <= 1'b0;
            immediate    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            ovf_flag     <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            cur_op       <= cur_op_nx;
            stackOP      <= stack_op_nx;
            aluOP        <= alu_op_nx;
            mux_selector <= mux_sel_nx;
            immediate    <= imm_nx;
            done         <= done_nx;
            err          <= err_nx;
            err_code     <= err_code_nx;
            ovf_flag     <= ovf_nx;
        end
    end

    // Next-state and next-output decode; stackOP falls back to NOP every cycle
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cur_op_nx   = cur_op;
        stack_op_nx = SOP_NOP;
        alu_op_nx   = aluOP;
        mux_sel_nx  = mux_selector;
        imm_nx      = immediate;
        done_nx     = 1'b0;
        err_nx      = err;
        err_code_nx = err_code;
        ovf_nx      = ovf_flag;
        depth_inc   = 1'b0;
        depth_dec   = 1'b0;
        depth_clr   = 1'b0;

        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    cur_op_nx = instr_op;
                    if (chk_code != ERR_NONE) begin
                        state_nx    = S_ERR;
                        err_nx      = 1'b1;
                        err_code_nx = chk_code;
                    end else begin
                        case (instr_op)
                            OP_PUSHI: begin
                                state_nx    = S_COMMIT;
                                stack_op_nx = SOP_PUSH;
                                mux_sel_nx  = 1'b1;
                                imm_nx      = instr_imm;
                            end
                            OP_POP: begin
                                state_nx    = S_COMMIT;
                                stack_op_nx = SOP_POP;
                            end
                            OP_ALU: begin
                                alu_op_nx  = instr_alu;
                                mux_sel_nx = 1'b0;
                                if (ALU_LAT == 0) begin
                                    state_nx    = S_COMMIT;
                                    stack_op_nx = SOP_POP2PUSH;
                                end else begin
                                    state_nx = S_SETTLE;
                                    cnt_nx   = CNT_W'(ALU_LAT - 1);
                                end
                            end
                            default: begin
                                state_nx    = S_COMMIT;
                                stack_op_nx = SOP_CLEAR;
                            end
                        endcase
                    end
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_nx    = S_COMMIT;
                    stack_op_nx = SOP_POP2PUSH;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_COMMIT: begin
                state_nx = S_IDLE;
                done_nx  = 1'b1;
                case (cur_op)
                    OP_PUSHI: depth_inc = 1'b1;
                    OP_POP:   depth_dec = 1'b1;
                    OP_ALU: begin
                        depth_dec = 1'b1;
                        ovf_nx    = ovf_flag | Overflow;
                    end
                    default: begin
                        depth_clr = 1'b1;
                        ovf_nx    = 1'b0;
                    end
                endcase
            end
            S_ERR: begin
                if (instr_valid && instr_op == OP_CLEAR) begin
                    state_nx    = S_IDLE;
                    err_nx      = 1'b0;
                    err_code_nx = ERR_NONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomised self-checking bench for stack_sequencer against a stack-level model.
module tb_stack_sequencer;

    localparam int DEPTH   = 8;
    localparam int ALU_LAT = 1;
    localparam int W       = 16;
    localparam int DW      = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [1:0]    instr_op;
    logic [W-1:0]  instr_imm;
    logic [3:0]    instr_alu;
    logic          Overflow;
    logic [2:0]    stackOP;
    logic [3:0]    aluOP;
    logic          mux_selector;
    logic [W-1:0]  immediate;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic          ovf_flag;
    logic [DW-1:0] depth;

    always #5 CLK = ~CLK;

    stack_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .W(W)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_imm    (instr_imm),
        .instr_alu    (instr_alu),
        .Overflow     (Overflow),
        .stackOP      (stackOP),
        .aluOP        (aluOP),
        .mux_selector (mux_selector),
        .immediate    (immediate),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .ovf_flag     (ovf_flag),
        .depth        (depth)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stack contents, sticky overflow and last ALU op
    logic [W-1:0] stk[$];
    bit           m_ovf;
    logic [3:0]   m_alu;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  instr_ready,  1);
        check({tag, "_sop"},    stackOP,      0);
        check({tag, "_alu"},    aluOP,        0);
        check({tag, "_mux"},    mux_selector, 0);
        check({tag, "_imm"},    immediate,    0);
        check({tag, "_done"},   done,         0);
        check({tag, "_err"},    err,          0);
        check({tag, "_ecode"},  err_code,     0);
        check({tag, "_ovf"},    ovf_flag,     0);
        check({tag, "_depth"},  depth,        0);
    endtask

    task automatic offer(input logic [1:0] op, input logic [W-1:0] imm, input logic [3:0] alu);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_imm   = imm;
        instr_alu   = alu;
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
        instr_op    = 2'($urandom);
        instr_imm   = W'($urandom);
        instr_alu   = 4'($urandom);
        @(negedge CLK);
    endtask

    // Issue one instruction from IDLE and check every cycle until it finishes
    task automatic exec(input logic [1:0] op, input logic [W-1:0] imm, input logic [3:0] alu);
        int           d;
        logic [1:0]   ecode;
        logic [W-1:0] a, b, r;
        bit           ovf_in;
        logic [2:0]   sop;
        d     = stk.size();
        ecode = 2'd0;
        if (op == 2'd0 && d == DEPTH) ecode = 2'd1;
        if (op == 2'd1 && d == 0)     ecode = 2'd2;
        if (op == 2'd2 && d < 2)      ecode = 2'd2;
        check("ready_pre", instr_ready, 1);
        offer(op, imm, alu);
        if (ecode != 2'd0) begin
            check("err_set",   err,         1);
            check("err_code",  err_code,    ecode);
            check("err_sop",   stackOP,     0);
            check("err_ready", instr_ready, 0);
            check("err_done",  done,        0);
            check("err_depth", depth,       d);
            offer(2'($urandom_range(0, 2)), W'($urandom), 4'($urandom));
            check("err_hold",       err,      1);
            check("err_hold_code",  err_code, ecode);
            check("err_hold_sop",   stackOP,  0);
            check("err_hold_depth", depth,    d);
            offer(2'd3, W'($urandom), 4'($urandom));
            check("errclr_err",   err,         0);
            check("errclr_code",  err_code,    0);
            check("errclr_ready", instr_ready, 1);
            check("errclr_done",  done,        0);
            check("errclr_sop",   stackOP,     0);
            check("errclr_depth", depth,       d);
            check("errclr_alu",   aluOP,       m_alu);
        end else if (op == 2'd2) begin
            b = stk.pop_back();
            a = stk.pop_back();
            r = a + b;
            if (alu == 4'd0)
                ovf_in = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            else
                ovf_in = bit'($urandom_range(0, 1));
            m_alu = alu;
            for (int k = 0; k < ALU_LAT; k++) begin
                check("settle_sop",   stackOP,      0);
                check("settle_alu",   aluOP,        alu);
                check("settle_mux",   mux_selector, 0);
                check("settle_ready", instr_ready,  0);
                check("settle_done",  done,         0);
                Overflow = !ovf_in;
                @(negedge CLK);
            end
            check("alu_commit_sop",  stackOP,      3);
            check("alu_commit_alu",  aluOP,        alu);
            check("alu_commit_mux",  mux_selector, 0);
            check("alu_commit_done", done,         0);
            Overflow = ovf_in;
            @(negedge CLK);
            Overflow = 1'b0;
            stk.push_back(r);
            m_ovf = m_ovf | ovf_in;
            check("alu_done",  done,        1);
            check("alu_depth", depth,       stk.size());
            check("alu_ovf",   ovf_flag,    m_ovf);
            check("alu_sop",   stackOP,     0);
            check("alu_ready", instr_ready, 1);
        end else begin
            sop = (op == 2'd0) ? 3'd1 : (op == 2'd1) ? 3'd2 : 3'd4;
            check("commit_sop",   stackOP,     sop);
            check("commit_ready", instr_ready, 0);
            check("commit_done",  done,        0);
            check("commit_err",   err,         0);
            check("commit_alu",   aluOP,       m_alu);
            if (op == 2'd0) begin
                check("pushi_mux", mux_selector, 1);
                check("pushi_imm", immediate,    imm);
                stk.push_back(imm);
            end else if (op == 2'd1) begin
                void'(stk.pop_back());
            end else begin
                stk.delete();
                m_ovf = 1'b0;
            end
            @(negedge CLK);
            check("done",     done,        1);
            check("done_sop", stackOP,     0);
            check("depth",    depth,       stk.size());
            check("ovf",      ovf_flag,    m_ovf);
            check("ready",    instr_ready, 1);
        end
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] imm;
        int           pick;
        reset       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = 2'd0;
        instr_imm   = '0;
        instr_alu   = 4'd0;
        Overflow    = 1'b0;
        m_ovf       = 1'b0;
        m_alu       = 4'd0;
        repeat (3) @(negedge CLK);
        check_reset_vals("in_reset");
        reset = 1'b1;
        @(negedge CLK);
        check_reset_vals("post_reset");

        // Directed sequence from the plan
        exec(2'd0, 16'h0005, 4'd0);
        exec(2'd0, 16'h0003, 4'd0);
        exec(2'd2, '0, 4'd0);
        check("first_add_ovf", ovf_flag, 0);
        exec(2'd0, 16'h7FFF, 4'd0);
        exec(2'd0, 16'h7FFF, 4'd0);
        exec(2'd2, '0, 4'd0);
        check("big_add_ovf", ovf_flag, 1);
        exec(2'd3, '0, 4'd0);
        check("clear_ovf", ovf_flag, 0);
        exec(2'd1, '0, 4'd0);
        for (int i = 0; i < DEPTH; i++) exec(2'd0, W'($urandom), 4'd0);
        check("full_depth", depth, DEPTH);
        exec(2'd0, 16'h1234, 4'd0);
        exec(2'd3, '0, 4'd0);
        exec(2'd0, 16'h0001, 4'd0);
        exec(2'd2, '0, 4'd5);

        // Randomised instruction stream
        for (int i = 0; i < 250; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 42)      op = 2'd0;
            else if (pick < 62) op = 2'd1;
            else if (pick < 92) op = 2'd2;
            else                op = 2'd3;
            case ($urandom_range(0, 3))
                0:       imm = 16'h7FFF;
                1:       imm = 16'h8000;
                default: imm = W'($urandom);
            endcase
            exec(op, imm, (pick[0]) ? 4'd0 : 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                check("idle_gap_done", done, 0);
            end
        end

        // Reset in the middle of an ALU settle cycle
        if (stk.size() == DEPTH) exec(2'd1, '0, 4'd0);
        while (stk.size() < 2) exec(2'd0, 16'h7FFF, 4'd0);
        exec(2'd0, 16'h7FFF, 4'd0);
        exec(2'd0, 16'h7FFF, 4'd0);
        exec(2'd2, '0, 4'd0);
        check("pre_rst_ovf", ovf_flag, 1);
        offer(2'd2, '0, 4'd9);
        check("mid_settle_alu", aluOP, 9);
        #1;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        stk.delete();
        m_ovf = 1'b0;
        m_alu = 4'd0;
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check_reset_vals("after_rst");
        exec(2'd0, 16'h00AA, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Instruction-level controller for the stack/ALU/mux push-pop datapath. Accepts one instruction per valid/ready handshake and drives the registered stackOP, aluOP, mux_selector and immediate controls for the required number of cycles. Tracks stack depth to detect overflow and underflow. Latches ALU overflow into a sticky status flag. Sits between the instruction source and the register_stack/alu/mux1 datapath.

Parameters:
DEPTH, 8, number of stack entries; sets the overflow limit.
ALU_LAT, 1, settle cycles with aluOP driven before commit; 0 is legal.
W, 16, data width of immediate.

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept; equals (state==IDLE)
instr_op  input  2  00 PUSHI, 01 POP, 10 ALU, 11 CLEAR
instr_imm  input  W  immediate value for PUSHI
instr_alu  input  4  ALU operation for ALU instruction
Overflow  input  1  ALU overflow from datapath
stackOP  output  3  stack command, registered
aluOP  output  4  ALU operation, registered
mux_selector  output  1  0 = ALU_out, 1 = immediate; registered
immediate  output  W  value for mux i1, registered
done  output  1  one-cycle pulse when an instruction commits
err  output  1  high while in ERR state
err_code  output  2  00 none, 01 overflow, 10 underflow
ovf_flag  output  1  sticky ALU overflow
depth  output  $clog2(DEPTH+1)  current stack occupancy

Behaviour:
- Stack encodings: NOP=3'd0, PUSH=3'd1, POP=3'd2, POP2PUSH=3'd3 (pop a and b, push w), CLEAR=3'd4.
- Reset (reset=0, asynchronous): state IDLE, stackOP=NOP, aluOP=0, mux_selector=0, immediate=0, done=0, err=0, err_code=0, ovf_flag=0, depth=0. Reset mid-instruction abandons it; the stack is cleared by the same reset.
- States: IDLE, SETTLE, COMMIT, ERR.
- Accept happens at cycle T when instr_valid & instr_ready. The instruction is checked against depth sampled at T:
  - PUSHI with depth==DEPTH: overflow (01).
  - POP with depth==0: underflow (10).
  - ALU with depth<2: underflow (10).
  - On error, ERR is entered at T+1 with err=1, err_code set and stackOP=NOP. The stack is not modified.
- PUSHI, POP, CLEAR:
  - T+1: COMMIT. PUSHI drives stackOP=PUSH, mux_selector=1, immediate=instr_imm. POP drives POP. CLEAR drives CLEAR.
  - T+2: IDLE, done=1, depth updated (+1 / -1 / 0), stackOP=NOP.
- ALU:
  - T+1..T+ALU_LAT: SETTLE with aluOP=instr_alu, mux_selector=0, stackOP=NOP. A cycle counter runs from ALU_LAT-1 down to 0.
  - T+ALU_LAT+1: COMMIT with stackOP=POP2PUSH and aluOP held. Overflow is sampled at the end of this cycle and ORed into ovf_flag.
  - Next cycle: IDLE, done=1, depth-1.
  - ALU_LAT=0 goes straight to COMMIT.
- aluOP holds its last value outside ALU instructions.
- ovf_flag is cleared only by CLEAR commit or reset. Set and clear in the same cycle is impossible by construction.
- ERR: instr_ready=0 and instructions are ignored. The err_clr condition is instr_valid with instr_op==CLEAR. It is consumed (no stack action, no done) and returns to IDLE next cycle with err=0 and err_code=0.
- Throughput: 2 cycles per non-ALU instruction, ALU_LAT+2 per ALU instruction. No overlap.
- Depth never wraps; the error checks guarantee 0 ≤ depth ≤ DEPTH.

Decomposition:
- Shared package stack_ctrl_pkg: stackOP encodings, instruction opcodes, err codes, state enum. register_stack uses the same stackOP constants.
- One natural sub-module, stack_depth_tracker: depth register, inc/dec/clear inputs, full/empty/lt2 outputs.

Test Plan:
- Reset release: depth=0, instr_ready=1, all outputs at reset values.
- PUSHI 16'h0005 then PUSHI 16'h0003 -> each shows stackOP=1, mux_selector=1, immediate correct for 1 cycle; done pulses; depth=2.
- ALU add (instr_alu=0) with ALU_LAT=1 -> 1 SETTLE cycle with aluOP=0 and stackOP=0, then 1 cycle of stackOP=3; done; depth=1; ovf_flag=0.
- PUSHI 16'h7FFF twice then ALU add -> Overflow=1 at commit; ovf_flag=1. A following CLEAR -> depth=0, ovf_flag=0.
- POP at depth 0 -> err=1, err_code=2, stackOP stays 0, instr_ready=0. Offer CLEAR -> err=0 next cycle; depth unchanged.
- Fill to DEPTH=8, then PUSHI -> err_code=1. Assert reset low during an ALU SETTLE -> immediate return to IDLE with all reset values.
